msi_snoop_bus_arbiter: RTL and testbench

Shared-bus arbiter and broadcaster for the MSI coherence fabric. It sits directly upstream of every cache's bus-request snoop FSM. It takes miss and invalidate requests from N caches and grants one transaction at a time, round-robin. It broadcasts the transaction as one-hot `bus_read_miss` / `bus_write_miss` / `bus_invalidate` pulses with an address, collects the snoopers' write-back/abort responses, and sequences the memory write-back or read before signalling completion to the requester.

---
 rtl/msi_snoop_bus_arbiter_if.sv | 44 ++++
 rtl/msi_snoop_bus_arbiter.sv | 139 +++++++++++++
 tb/tb_msi_snoop_bus_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/msi_snoop_bus_arbiter_if.sv
// Bundle of request, broadcast, snoop-response and memory signals around the MSI bus arbiter.
// The arbiter connects through master; caches and memory connect through slave.
interface msi_snoop_bus_arbiter_if #(
  parameter int N_CACHES = 4,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16
);
  localparam int SRC_W = $clog2(N_CACHES);

  logic [N_CACHES-1:0]        req_valid;
  logic [2*N_CACHES-1:0]      req_type;
  logic [ADDR_W*N_CACHES-1:0] req_addr;
  logic                       bus_valid;
  logic                       bus_read_miss;
  logic                       bus_write_miss;
  logic                       bus_invalidate;
  logic [ADDR_W-1:0]          bus_addr;
  logic [SRC_W-1:0]           bus_src;
  logic [N_CACHES-1:0]        snoop_wb;
  logic [N_CACHES-1:0]        snoop_abort;
  logic [DATA_W*N_CACHES-1:0] snoop_wb_data;
  logic                       mem_rd;
  logic                       mem_wr;
  logic [ADDR_W-1:0]          mem_addr;
  logic [DATA_W-1:0]          mem_wdata;
  logic [DATA_W-1:0]          mem_rdata;
  logic                       mem_ack;
  logic [N_CACHES-1:0]        done;
  logic [DATA_W-1:0]          done_data;

  modport master (
    input  req_valid, req_type, req_addr, snoop_wb, snoop_abort, snoop_wb_data,
           mem_rdata, mem_ack,
    output bus_valid, bus_read_miss, bus_write_miss, bus_invalidate, bus_addr, bus_src,
           mem_rd, mem_wr, mem_addr, mem_wdata, done, done_data
  );

  modport slave (
    output req_valid, req_type, req_addr, snoop_wb, snoop_abort, snoop_wb_data,
           mem_rdata, mem_ack,
    input  bus_valid, bus_read_miss, bus_write_miss, bus_invalidate, bus_addr, bus_src,
           mem_rd, mem_wr, mem_addr, mem_wdata, done, done_data
  );
endinterface

// File: rtl/msi_snoop_bus_arbiter.sv
// Round-robin shared-bus arbiter for the MSI fabric: grants one cache, broadcasts the
// transaction, resolves snoop write-back/abort, sequences memory and signals completion.
module msi_snoop_bus_arbiter #(
  parameter int N_CACHES = 4,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16
) (
  input logic                   clk,
  input logic                   reset,
  msi_snoop_bus_arbiter_if.master bus
);
  localparam int SRC_W = $clog2(N_CACHES);
  localparam logic [1:0] T_RD  = 2'b01;
  localparam logic [1:0] T_WR  = 2'b10;
  localparam logic [1:0] T_INV = 2'b11;

  typedef enum logic [2:0] {IDLE, BCAST, SNOOP, WB, MEMRD, DONE} state_t;

  state_t              state, state_nxt;
  logic [SRC_W-1:0]    last_grant;
  logic [SRC_W-1:0]    pick, owner;
  logic                found, owner_found;
  int                  rr_idx;
  logic [N_CACHES-1:0] wb_masked;

  logic [SRC_W-1:0]    src_q;
  logic [1:0]          type_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                abort_q;

  // Round-robin search starting just after the previous winner; type 00 is not a request.
  always_comb begin
    found  = 1'b0;
    pick   = '0;
    rr_idx = 0;
    for (int k = 1; k <= N_CACHES; k++) begin
      rr_idx = (int'(last_grant) + k) % N_CACHES;
      if (!found && bus.req_valid[rr_idx] && (bus.req_type[2*rr_idx +: 2] != 2'b00)) begin
        found = 1'b1;
        pick  = SRC_W'(rr_idx);
      end
    end
  end

  // The requester never supplies its own block, so its snoop bit is masked off.
  assign wb_masked = bus.snoop_wb & ~(N_CACHES'(1) << src_q);

  always_comb begin
    owner_found = 1'b0;
    owner       = '0;
    for (int i = N_CACHES - 1; i >= 0; i--) begin
      if (wb_masked[i]) begin
        owner_found = 1'b1;
        owner       = SRC_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= SRC_W'(N_CACHES - 1);
    end else begin
      state <= state_nxt;
      if (state == BCAST) last_grant <= src_q;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = BCAST;
      BCAST:   state_nxt = SNOOP;
      SNOOP: begin
        if (owner_found)          state_nxt = WB;
        else if (type_q != T_INV) state_nxt = MEMRD;
        else                      state_nxt = DONE;
      end
      WB:      if (bus.mem_ack) state_nxt = abort_q ? DONE : MEMRD;
      MEMRD:   if (bus.mem_ack) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction latches carry no reset: every output that exposes them is gated by state.
  always_ff @(posedge clk) begin
    if (state == IDLE && found) begin
      src_q  <= pick;
      type_q <= bus.req_type[2*int'(pick) +: 2];
      addr_q <= bus.req_addr[ADDR_W*int'(pick) +: ADDR_W];
    end
    if (state == SNOOP && owner_found) begin
      data_q  <= bus.snoop_wb_data[DATA_W*int'(owner) +: DATA_W];
      abort_q <= bus.snoop_abort[owner];
    end
    if (state == MEMRD && bus.mem_ack) data_q <= bus.mem_rdata;
  end

  always_comb begin
    bus.bus_valid      = 1'b0;
    bus.bus_read_miss  = 1'b0;
    bus.bus_write_miss = 1'b0;
    bus.bus_invalidate = 1'b0;
    bus.bus_addr       = '0;
    bus.bus_src        = '0;
    bus.mem_rd         = 1'b0;
    bus.mem_wr         = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_wdata      = '0;
    bus.done           = '0;
    bus.done_data      = '0;
    case (state)
      BCAST: begin
        bus.bus_valid      = 1'b1;
        bus.bus_read_miss  = (type_q == T_RD);
        bus.bus_write_miss = (type_q == T_WR);
        bus.bus_invalidate = (type_q == T_INV);
        bus.bus_addr       = addr_q;
        bus.bus_src        = src_q;
      end
      WB: begin
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = data_q;
      end
      MEMRD: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = addr_q;
      end
      DONE: begin
        bus.done      = N_CACHES'(1) << src_q;
        bus.done_data = (type_q == T_INV) ? '0 : data_q;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_msi_snoop_bus_arbiter.sv
// Self-checking bench for msi_snoop_bus_arbiter: directed scenarios plus randomized
// transactions compared against a transaction-level reference model.
module tb_msi_snoop_bus_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  msi_snoop_bus_arbiter_if #(.N_CACHES(N), .ADDR_W(AW), .DATA_W(DW)) bif ();
  msi_snoop_bus_arbiter #(.N_CACHES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .bus(bif)
  );

  int checks = 0;
  int errors = 0;
  int m_last;

  int          ob_bc_cnt, ob_src, ob_bcast_cyc, ob_done_cyc, ob_wr_cyc, ob_rd_cyc, ob_bad;
  logic [2:0]  ob_kind;
  logic [AW-1:0] ob_baddr, ob_waddr, ob_raddr;
  logic [DW-1:0] ob_wdata, ob_ddata;
  logic [N-1:0]  ob_done;
  bit          ob_timeout;

  task automatic clear_inputs();
    bif.req_valid = '0; bif.req_type = '0; bif.req_addr = '0;
    bif.snoop_wb = '0; bif.snoop_abort = '0; bif.snoop_wb_data = '0;
    bif.mem_rdata = '0; bif.mem_ack = 1'b0;
  endtask

  task automatic set_req(input int c, input logic [1:0] t, input logic [AW-1:0] a, input logic v);
    bif.req_valid[c] = v;
    bif.req_type[2*c +: 2] = t;
    bif.req_addr[AW*c +: AW] = a;
  endtask

  task automatic set_snoop(input int c, input logic wb, input logic ab, input logic [DW-1:0] d);
    bif.snoop_wb[c] = wb;
    bif.snoop_abort[c] = ab;
    bif.snoop_wb_data[DW*c +: DW] = d;
  endtask

  function automatic logic [2:0] kind_of(input logic [1:0] t);
    case (t)
      2'b01:   return 3'b100;
      2'b10:   return 3'b010;
      2'b11:   return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // Plays memory (ack after lat command cycles) and records one transaction up to its done pulse.
  task automatic run_txn(input int lat, input bit drop, input bit noise);
    int cyc = 0;
    int wr_run = 0;
    int rd_run = 0;
    ob_bc_cnt = 0; ob_src = -1; ob_bcast_cyc = -1; ob_done_cyc = -1;
    ob_wr_cyc = 0; ob_rd_cyc = 0; ob_bad = 0; ob_kind = '0;
    ob_baddr = '0; ob_waddr = '0; ob_raddr = '0; ob_wdata = '0; ob_ddata = '0; ob_done = '0;
    ob_timeout = 1'b1;
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      bif.mem_ack = 1'b0;
      if (bif.bus_valid) begin
        ob_bc_cnt++;
        ob_kind = {bif.bus_read_miss, bif.bus_write_miss, bif.bus_invalidate};
        ob_baddr = bif.bus_addr;
        ob_src = int'(bif.bus_src);
        ob_bcast_cyc = cyc;
      end else if (bif.bus_read_miss || bif.bus_write_miss || bif.bus_invalidate) begin
        ob_bad++;
      end
      if (bif.mem_rd && bif.mem_wr) ob_bad++;
      if (bif.mem_wr) begin
        ob_wr_cyc++; wr_run++; ob_waddr = bif.mem_addr; ob_wdata = bif.mem_wdata;
        if (wr_run == lat) bif.mem_ack = 1'b1;
      end else wr_run = 0;
      if (bif.mem_rd) begin
        ob_rd_cyc++; rd_run++; ob_raddr = bif.mem_addr;
        if (rd_run == lat) bif.mem_ack = 1'b1;
      end else rd_run = 0;
      if (!bif.mem_rd && !bif.mem_wr && noise) bif.mem_ack = 1'($urandom_range(0, 1));
      if (bif.done != '0) begin
        ob_done = bif.done; ob_ddata = bif.done_data; ob_done_cyc = cyc; ob_timeout = 1'b0;
        bif.mem_ack = 1'b0;
        if (drop) bif.req_valid = bif.req_valid & ~bif.done;
        break;
      end
    end
    bif.mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ((|{bif.bus_valid, bif.bus_read_miss, bif.bus_write_miss, bif.bus_invalidate, bif.bus_addr, bif.bus_src, bif.mem_rd, bif.mem_wr, bif.mem_addr, bif.mem_wdata}) !== 1'b0) begin errors++; $display("FAIL reset_bus_mem got nonzero outputs expected all 0"); end
    checks++; if ({bif.done, bif.done_data} !== '0) begin errors++; $display("FAIL reset_done got %0h expected 0", {bif.done, bif.done_data}); end
    reset = 1'b0;
    m_last = N - 1;
  endtask

  task automatic test_invalidate();
    clear_inputs();
    set_req(2, 2'b11, 8'h3C, 1'b1);
    run_txn(2, 1'b1, 1'b0);
    checks++; if (ob_timeout !== 1'b0) begin errors++; $display("FAIL inv_timeout got no done expected done"); end
    checks++; if (ob_bc_cnt !== 1 || ob_kind !== 3'b001) begin errors++; $display("FAIL inv_bcast got cnt %0d kind %b expected 1 001", ob_bc_cnt, ob_kind); end
    checks++; if (ob_src !== 2 || ob_baddr !== 8'h3C) begin errors++; $display("FAIL inv_src_addr got %0d %0h expected 2 3c", ob_src, ob_baddr); end
    checks++; if (ob_done !== 4'b0100 || ob_ddata !== 16'h0) begin errors++; $display("FAIL inv_done got %b %0h expected 0100 0", ob_done, ob_ddata); end
    checks++; if (ob_done_cyc - ob_bcast_cyc !== 2) begin errors++; $display("FAIL inv_latency got %0d expected 2", ob_done_cyc - ob_bcast_cyc); end
    checks++; if (ob_wr_cyc + ob_rd_cyc !== 0 || ob_bad !== 0) begin errors++; $display("FAIL inv_no_mem got mem %0d bad %0d expected 0 0", ob_wr_cyc + ob_rd_cyc, ob_bad); end
    m_last = 2;
  endtask

  task automatic test_clean_read();
    clear_inputs();
    set_req(0, 2'b01, 8'h10, 1'b1);
    bif.mem_rdata = 16'hBEEF;
    run_txn(3, 1'b1, 1'b0);
    checks++; if (ob_src !== 0 || ob_kind !== 3'b100 || ob_baddr !== 8'h10) begin errors++; $display("FAIL rd_bcast got src %0d kind %b addr %0h expected 0 100 10", ob_src, ob_kind, ob_baddr); end
    checks++; if (ob_rd_cyc !== 3 || ob_raddr !== 8'h10 || ob_wr_cyc !== 0) begin errors++; $display("FAIL rd_mem got rd %0d addr %0h wr %0d expected 3 10 0", ob_rd_cyc, ob_raddr, ob_wr_cyc); end
    checks++; if (ob_done !== 4'b0001 || ob_ddata !== 16'hBEEF) begin errors++; $display("FAIL rd_done got %b %0h expected 0001 beef", ob_done, ob_ddata); end
    checks++; if (ob_done_cyc - ob_bcast_cyc !== 5) begin errors++; $display("FAIL rd_latency got %0d expected 5", ob_done_cyc - ob_bcast_cyc); end
    m_last = 0;
  endtask

  task automatic test_dirty_write();
    clear_inputs();
    set_req(1, 2'b10, 8'h22, 1'b1);
    set_snoop(3, 1'b1, 1'b1, 16'h1234);
    set_snoop(1, 1'b0, 1'b0, 16'hDEAD);
    bif.mem_rdata = 16'h9999;
    run_txn(2, 1'b1, 1'b0);
    checks++; if (ob_src !== 1 || ob_kind !== 3'b010 || ob_baddr !== 8'h22) begin errors++; $display("FAIL wm_bcast got src %0d kind %b addr %0h expected 1 010 22", ob_src, ob_kind, ob_baddr); end
    checks++; if (ob_wr_cyc !== 2 || ob_waddr !== 8'h22 || ob_wdata !== 16'h1234) begin errors++; $display("FAIL wm_wb got cyc %0d addr %0h data %0h expected 2 22 1234", ob_wr_cyc, ob_waddr, ob_wdata); end
    checks++; if (ob_rd_cyc !== 0) begin errors++; $display("FAIL wm_no_read got %0d expected 0", ob_rd_cyc); end
    checks++; if (ob_done !== 4'b0010 || ob_ddata !== 16'h1234) begin errors++; $display("FAIL wm_done got %b %0h expected 0010 1234", ob_done, ob_ddata); end
    checks++; if (ob_done_cyc - ob_bcast_cyc !== 4) begin errors++; $display("FAIL wm_latency got %0d expected 4", ob_done_cyc - ob_bcast_cyc); end
    m_last = 1;
  endtask

  task automatic test_self_mask();
    clear_inputs();
    set_req(3, 2'b01, 8'h7F, 1'b1);
    set_snoop(3, 1'b1, 1'b1, 16'hAAAA);
    bif.mem_rdata = 16'h5A5A;
    run_txn(1, 1'b1, 1'b0);
    checks++; if (ob_src !== 3 || ob_wr_cyc !== 0 || ob_rd_cyc !== 1) begin errors++; $display("FAIL self_mask got src %0d wr %0d rd %0d expected 3 0 1", ob_src, ob_wr_cyc, ob_rd_cyc); end
    checks++; if (ob_done !== 4'b1000 || ob_ddata !== 16'h5A5A) begin errors++; $display("FAIL self_done got %b %0h expected 1000 5a5a", ob_done, ob_ddata); end
    m_last = 3;
  endtask

  task automatic test_round_robin();
    clear_inputs();
    reset = 1'b1;
    set_req(0, 2'b01, 8'h50, 1'b1);
    set_req(1, 2'b10, 8'h51, 1'b1);
    set_req(2, 2'b11, 8'h52, 1'b1);
    set_req(3, 2'b01, 8'h53, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_last = N - 1;
    for (int i = 0; i < 5; i++) begin
      run_txn(1, 1'b0, 1'b0);
      checks++; if (ob_timeout !== 1'b0 || ob_src !== i % N || ob_done !== (N'(1) << (i % N))) begin errors++; $display("FAIL rr_grant_%0d got src %0d done %b expected %0d", i, ob_src, ob_done, i % N); end
    end
    clear_inputs();
    m_last = 0;
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    bit hit = 1'b0;
    clear_inputs();
    set_req(1, 2'b01, 8'h44, 1'b1);
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      if (bif.mem_rd) seen++;
      if (seen == 2) begin reset = 1'b1; hit = 1'b1; end
    end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL rmid_reach got %0d rd cycles expected 2", seen); end
    @(negedge clk);
    checks++; if ((|{bif.bus_valid, bif.bus_read_miss, bif.bus_write_miss, bif.bus_invalidate, bif.bus_addr, bif.bus_src, bif.mem_rd, bif.mem_wr, bif.mem_addr, bif.mem_wdata, bif.done, bif.done_data}) !== 1'b0) begin errors++; $display("FAIL rmid_outputs got nonzero expected all 0 (done %b rd %b)", bif.done, bif.mem_rd); end
    reset = 1'b0;
    clear_inputs();
    set_req(0, 2'b11, 8'h01, 1'b1);
    set_req(2, 2'b11, 8'h02, 1'b1);
    run_txn(1, 1'b1, 1'b0);
    checks++; if (ob_timeout !== 1'b0 || ob_src !== 0 || ob_done !== 4'b0001) begin errors++; $display("FAIL rmid_first got src %0d done %b expected 0 0001", ob_src, ob_done); end
    run_txn(1, 1'b1, 1'b0);
    checks++; if (ob_src !== 2 || ob_baddr !== 8'h02) begin errors++; $display("FAIL rmid_second got src %0d addr %0h expected 2 02", ob_src, ob_baddr); end
    m_last = 2;
  endtask

  task automatic test_random();
    bit pv[N];
    logic [1:0] pt[N];
    logic [AW-1:0] pa[N];
    logic [N-1:0] swb, sab;
    logic [DW-1:0] sd[N];
    logic [DW-1:0] rdata, exp_dd;
    int lat, win, own, exp_lat;
    bit exp_wr, exp_rd, any;
    for (int c = 0; c < N; c++) pv[c] = 1'b0;
    clear_inputs();
    for (int it = 0; it < 60; it++) begin
      any = 1'b0;
      for (int c = 0; c < N; c++) begin
        if (!pv[c] && $urandom_range(0, 1) == 1) begin
          pv[c] = 1'b1; pt[c] = 2'($urandom_range(1, 3)); pa[c] = AW'($urandom);
        end
        any |= pv[c];
      end
      if (!any) begin
        win = $urandom_range(0, N - 1);
        pv[win] = 1'b1; pt[win] = 2'($urandom_range(1, 3)); pa[win] = AW'($urandom);
      end
      swb = N'($urandom); sab = N'($urandom);
      for (int c = 0; c < N; c++) begin
        sd[c] = DW'($urandom);
        set_snoop(c, swb[c], sab[c], sd[c]);
        if (pv[c]) set_req(c, pt[c], pa[c], 1'b1);
        else if ($urandom_range(0, 3) == 0) set_req(c, 2'b00, AW'($urandom), 1'b1);
        else set_req(c, 2'b00, 8'h00, 1'b0);
      end
      rdata = DW'($urandom);
      bif.mem_rdata = rdata;
      lat = $urandom_range(1, 4);
      win = -1;
      for (int k = 1; k <= N; k++) if (win < 0 && pv[(m_last + k) % N]) win = (m_last + k) % N;
      own = -1;
      for (int i = 0; i < N; i++) if (own < 0 && i != win && swb[i]) own = i;
      exp_wr = (own >= 0);
      exp_rd = (own >= 0) ? !sab[own] : (pt[win] != 2'b11);
      exp_dd = (pt[win] == 2'b11) ? '0 : (exp_wr && !exp_rd) ? sd[own] : rdata;
      exp_lat = 2 + (exp_wr ? lat : 0) + (exp_rd ? lat : 0);
      run_txn(lat, 1'b1, 1'b1);
      checks++; if (ob_timeout !== 1'b0 || ob_src !== win || ob_done !== (N'(1) << win)) begin errors++; $display("FAIL rnd%0d_grant got src %0d done %b expected %0d", it, ob_src, ob_done, win); end
      checks++; if (ob_bc_cnt !== 1 || ob_kind !== kind_of(pt[win]) || ob_baddr !== pa[win] || ob_bad !== 0) begin errors++; $display("FAIL rnd%0d_bcast got kind %b addr %0h cnt %0d expected %b %0h 1", it, ob_kind, ob_baddr, ob_bc_cnt, kind_of(pt[win]), pa[win]); end
      checks++; if (ob_wr_cyc !== (exp_wr ? lat : 0) || (exp_wr && (ob_wdata !== sd[own] || ob_waddr !== pa[win]))) begin errors++; $display("FAIL rnd%0d_wb got cyc %0d data %0h expected %0d %0h", it, ob_wr_cyc, ob_wdata, exp_wr ? lat : 0, exp_wr ? sd[own] : 16'h0); end
      checks++; if (ob_rd_cyc !== (exp_rd ? lat : 0) || (exp_rd && ob_raddr !== pa[win])) begin errors++; $display("FAIL rnd%0d_rd got cyc %0d addr %0h expected %0d %0h", it, ob_rd_cyc, ob_raddr, exp_rd ? lat : 0, pa[win]); end
      checks++; if (ob_ddata !== exp_dd || ob_done_cyc - ob_bcast_cyc !== exp_lat) begin errors++; $display("FAIL rnd%0d_done got data %0h lat %0d expected %0h %0d", it, ob_ddata, ob_done_cyc - ob_bcast_cyc, exp_dd, exp_lat); end
      if (win >= 0) begin pv[win] = 1'b0; m_last = win; end
    end
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_invalidate();
    test_clean_read();
    test_dirty_write();
    test_self_mask();
    test_round_robin();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
